// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port memory responder for the multicycle core.
// Accepts one load/store at a time, waits WAIT_CYCLES, performs the access on an
// internal byte-lane word array and returns data/error over a response handshake.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (misaligned half/word -> error).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Operands of the access: live inputs when there are no wait states,
  // otherwise the request captured on the accept edge.
  logic        acc_write;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  generate
    if (WAIT_CYCLES == 0) begin : g_direct
      assign acc_write = req_write;
      assign acc_f3    = req_funct3;
      assign acc_addr  = req_addr;
      assign acc_wdata = req_wdata;
    end else begin : g_captured
      assign acc_write = write_q;
      assign acc_f3    = funct3_q;
      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
    end
  endgenerate

  logic          do_access;
  logic          f3_ok;
  logic          range_ok;
  logic          err_d;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   rdata_d;
  logic          mem_we;

  // Access decode: legality, byte lane, byte enables and load extension.
  always_comb begin
    if (WAIT_CYCLES == 0) do_access = req_valid && (state_q == S_IDLE);
    else                  do_access = (state_q == S_WAIT) && (cnt_q == '0);

    f3_ok    = acc_write ? (acc_f3 inside {3'd0, 3'd1, 3'd2})
                         : (acc_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    range_ok = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_CHECK_EN
    err_d = !f3_ok || !range_ok ||
            ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
            ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    err_d = !f3_ok || !range_ok;
`endif

    // Halves and words ignore the address bits below their size.
    case (acc_f3[1:0])
      2'b01:   lane = {acc_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = acc_addr[1:0];
    endcase
    idx = acc_addr[AW+1:2];

    case (acc_f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wdata_lane = acc_wdata << {lane, 3'b000};

    shifted = rd_word >> {lane, 3'b000};
    case (acc_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = shifted;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = 32'd0;
    endcase

    rdata_d = (err_d || acc_write) ? 32'd0 : load_val;
    mem_we  = do_access && acc_write && !err_d && !rst;
  end

  // One byte-wide array per lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      // Lane write on a committed store that enables this byte.
      always_ff @(posedge clk) begin
        if (mem_we && be[gi]) mem_q[idx] <= wdata_lane[gi*8 +: 8];
      end
      assign rd_word[gi*8 +: 8] = mem_q[idx];
    end
  endgenerate

  // Request/wait/response sequencing with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            funct3_q    <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              rdata_q     <= rdata_d;
              err_q       <= err_d;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cnt_q   <= CW'(WAIT_CYCLES - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed requests, a byte-level memory
// model with a cycle-count timing model, and a per-cycle output compare.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mmem [DEPTH*4];

  task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int nb;
    int base;
    logic legal;
    logic [31:0] v;
    nb    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = !legal || (a >= 32'(DEPTH*4)) || (CHK && ((int'(a[1:0]) % nb) != 0));
    rd    = 32'd0;
    if (!e) begin
      base = int'(a[7:0]) - (int'(a[1:0]) % nb);
      if (w) begin
        for (int i = 0; i < nb; i++) mmem[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mmem[base+i]) << (8*i));
        if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  logic        m_busy = 1'b0;
  logic        m_resp = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err   = 1'b0;
  logic        p_w;
  logic [2:0]  p_f3;
  logic [31:0] p_a;
  logic [31:0] p_wd;
  logic        cmp_en = 1'b0;

  // Timing model: a response appears W edges after acceptance.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_resp = 1'b0; m_rdata = 32'd0; m_err = 1'b0;
      end else if (m_resp) begin
        if (rsp_ready) begin m_resp = 1'b0; m_busy = 1'b0; end
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == W) begin
          model_access(p_w, p_f3, p_a, p_wd, m_rdata, m_err);
          m_resp = 1'b1;
        end
      end else if (req_valid) begin
        p_w = req_write; p_f3 = req_funct3; p_a = req_addr; p_wd = req_wdata;
        m_busy = 1'b1; m_cnt = 0;
        if (W == 0) begin
          model_access(p_w, p_f3, p_a, p_wd, m_rdata, m_err);
          m_resp = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && rst === 1'b0) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
        if (m_resp) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic e, output int lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0; rd = 32'd0; e = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (rsp_valid !== 1'b1) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    end else begin
      rd = rsp_rdata; e = rsp_err;
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic req_chk(input string name, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic e;
    int lat;
    do_req(w, f3, a, wd, 0, rd, e, lat);
    $display("req %s: w=%0d f3=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
             name, w, f3, a, rd, e, lat);
    chk({name, "_rd"}, rd, exp_rd);
    chk({name, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);

    // sw then lw, with latency
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, e, lat);
    $display("req sw10: rdata=0x%08h err=%0d lat=%0d", rd, e, lat);
    chk("sw10_latency", 32'(lat), 32'd3);
    chk("sw10_err", 32'(e), 32'd0);
    chk("sw10_rd", rd, 32'd0);
    req_chk("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // byte/half extension
    req_chk("sw20",  1'b1, 3'd2, 32'h20, 32'h80FF7F01, 32'h0, 1'b0);
    req_chk("lb23",  1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
    req_chk("lbu23", 1'b0, 3'd4, 32'h23, 32'h0, 32'h00000080, 1'b0);
    req_chk("lh22",  1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0);
    req_chk("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, 32'h00007F01, 1'b0);
    req_chk("lb20",  1'b0, 3'd0, 32'h20, 32'h0, 32'h00000001, 1'b0);
    req_chk("sb21",  1'b1, 3'd0, 32'h21, 32'h123456AA, 32'h0, 1'b0);
    req_chk("lw20",  1'b0, 3'd2, 32'h20, 32'h0, 32'h80FFAA01, 1'b0);
    req_chk("sh22",  1'b1, 3'd1, 32'h22, 32'hABCD1234, 32'h0, 1'b0);
    req_chk("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 32'h1234AA01, 1'b0);

    // backpressure: hold rsp_ready low for 5 cycles in RESP
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 5, rd, e, lat);
    $display("req bp_lw20: rdata=0x%08h err=%0d lat=%0d", rd, e, lat);
    chk("bp_rd", rd, 32'h1234AA01);
    chk("bp_err", 32'(e), 32'd0);

    // range boundary and errors
    req_chk("swFC",  1'b1, 3'd2, 32'hFC, 32'h0BADCAFE, 32'h0, 1'b0);
    req_chk("lwFC",  1'b0, 3'd2, 32'hFC, 32'h0, 32'h0BADCAFE, 1'b0);
    req_chk("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    req_chk("lwhigh", 1'b0, 3'd2, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
    req_chk("st011", 1'b1, 3'd3, 32'h10, 32'h11111111, 32'h0, 1'b1);
    req_chk("ld011", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
    req_chk("ld110", 1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1);
    req_chk("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // misalignment
    if (CHK) begin
      req_chk("sw12", 1'b1, 3'd2, 32'h12, 32'h55667788, 32'h0, 1'b1);
      req_chk("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      req_chk("lh21", 1'b0, 3'd1, 32'h21, 32'h0, 32'h0, 1'b1);
    end else begin
      req_chk("sw12", 1'b1, 3'd2, 32'h12, 32'h55667788, 32'h0, 1'b0);
      req_chk("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, 32'h55667788, 1'b0);
      req_chk("lh21", 1'b0, 3'd1, 32'h21, 32'h0, 32'hFFFFAA01, 1'b0);
    end

    // reset during WAIT drops the pending store
    req_chk("sw30", 1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("req rst_mid: sw 0x30 aborted by reset in WAIT");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    req_chk("lw30", 1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
